// File: rtl/smart_lighting_pkg.sv
// Shared definitions for the smart-lighting command path.
// Holds the press-classifier state type and the default timing constants
// used by gerador_comandos and by the lamp FSM users of this package.
package smart_lighting_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } press_state_t;

  localparam int DEF_DEBOUNCE_CYC    = 100;
  localparam int DEF_LONG_PRESS_CYC  = 3000;
  localparam int DEF_OFF_TIMEOUT_CYC = 30000;

endpackage

// File: rtl/gerador_comandos_debouncer.sv
// debouncer: 2-FF synchroniser followed by a stability filter.
//   clk  in  system clock
//   rst  in  asynchronous active-low reset
//   din  in  raw asynchronous level
//   dout out debounced level; follows din only after it has differed from
//            the current output for DEBOUNCE_CYC consecutive cycles
module debouncer #(
  parameter int DEBOUNCE_CYC = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = (DEBOUNCE_CYC > 2) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= din;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign dout = stable_q;

endmodule

// File: rtl/gerador_comandos.sv
// gerador_comandos: turns raw push-button and infrared presence inputs into
// single-cycle command pulses for the lamp-mode FSM.
//   clk         in  system clock
//   rst         in  asynchronous active-low reset
//   push_button in  raw button level, 1 = pressed
//   infrared    in  raw presence sensor, 1 = presence
//   a           out pulse: long press (toggle auto/manual)
//   b           out pulse: short press released (toggle lamp, manual)
//   c           out pulse: absence timeout expired (lamp off, auto)
//   d           out pulse: presence rising edge (lamp on, auto)
module gerador_comandos #(
  parameter int DEBOUNCE_CYC    = smart_lighting_pkg::DEF_DEBOUNCE_CYC,
  parameter int LONG_PRESS_CYC  = smart_lighting_pkg::DEF_LONG_PRESS_CYC,
  parameter int OFF_TIMEOUT_CYC = smart_lighting_pkg::DEF_OFF_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic push_button,
  input  logic infrared,
  output logic a,
  output logic b,
  output logic c,
  output logic d
);

  import smart_lighting_pkg::*;

  localparam int PW = $clog2(LONG_PRESS_CYC + 1);
  localparam int TW = $clog2(OFF_TIMEOUT_CYC);
  localparam logic [PW-1:0] PRESS_LONG = PW'(LONG_PRESS_CYC);
  // The count register lags the increment by one, so expiry is detected
  // one below the advertised terminal value.
  localparam logic [TW-1:0] TIMER_LAST = TW'(OFF_TIMEOUT_CYC - 2);

  logic pb_stable;
  logic ir_sync1_q, ir_sync_q, ir_prev_q;

  press_state_t  state_q, state_d;
  logic [PW-1:0] press_cnt_q, press_cnt_d;
  logic          timer_run_q, timer_run_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;

  debouncer #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_pb_debounce (
    .clk  (clk),
    .rst  (rst),
    .din  (push_button),
    .dout (pb_stable)
  );

  // Press classifier: release before the long threshold is a short press.
  always_comb begin
    state_d     = state_q;
    press_cnt_d = press_cnt_q;
    a_d         = 1'b0;
    b_d         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pb_stable) begin
          state_d     = PRESSED;
          press_cnt_d = PW'(1);
        end
      end
      PRESSED: begin
        if (!pb_stable) begin
          state_d = IDLE;
          b_d     = 1'b1;
        end else if (press_cnt_q == PRESS_LONG) begin
          state_d = LONG_HELD;
          a_d     = 1'b1;
        end else begin
          press_cnt_d = press_cnt_q + 1'b1;
        end
      end
      LONG_HELD: begin
        if (!pb_stable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Presence edges and absence timer.
  always_comb begin
    timer_run_d = timer_run_q;
    timer_d     = timer_q;
    c_d         = 1'b0;
    d_d         = 1'b0;
    if (ir_sync_q && !ir_prev_q) begin
      d_d         = 1'b1;
      timer_run_d = 1'b0;
      timer_d     = '0;
    end else if (!ir_sync_q && ir_prev_q) begin
      timer_run_d = 1'b1;
      timer_d     = '0;
    end else if (timer_run_q && !ir_sync_q) begin
      if (timer_q == TIMER_LAST) begin
        c_d         = 1'b1;
        timer_run_d = 1'b0;
        timer_d     = '0;
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_sync1_q  <= 1'b0;
      ir_sync_q   <= 1'b0;
      ir_prev_q   <= 1'b0;
      state_q     <= IDLE;
      press_cnt_q <= '0;
      timer_run_q <= 1'b0;
      timer_q     <= '0;
      a_q         <= 1'b0;
      b_q         <= 1'b0;
      c_q         <= 1'b0;
      d_q         <= 1'b0;
    end else begin
      ir_sync1_q  <= infrared;
      ir_sync_q   <= ir_sync1_q;
      ir_prev_q   <= ir_sync_q;
      state_q     <= state_d;
      press_cnt_q <= press_cnt_d;
      timer_run_q <= timer_run_d;
      timer_q     <= timer_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
    end
  end

  assign a = a_q;
  assign b = b_q;
  assign c = c_q;
  assign d = d_q;

endmodule

// File: tb/tb_gerador_comandos.sv
module tb_gerador_comandos;

  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int OFF  = 50;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic push_button = 1'b0;
  logic infrared = 1'b0;
  logic a, b, c, d;

  gerador_comandos #(
    .DEBOUNCE_CYC    (DEB),
    .LONG_PRESS_CYC  (LONG),
    .OFF_TIMEOUT_CYC (OFF)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .push_button (push_button),
    .infrared    (infrared),
    .a           (a),
    .b           (b),
    .c           (c),
    .d           (d)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Cycle counter: number of rising edges seen since time 0.
  int cyc = 0;
  always @(posedge clk) cyc++;

  // Behavioural model, event/timestamp based.
  int  mc;
  bit  p1, p2, pst;
  int  run;
  bit  pressing;
  int  tp;
  bit  i1, i2, iprev;
  bit  armed;
  int  tf;
  bit  e_a, e_b, e_c, e_d;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mc = 0; p1 = 0; p2 = 0; pst = 0; run = 0;
      pressing = 0; tp = 0;
      i1 = 0; i2 = 0; iprev = 0; armed = 0; tf = 0;
      e_a = 0; e_b = 0; e_c = 0; e_d = 0;
    end else begin
      mc++;
      e_a = 0; e_b = 0; e_c = 0; e_d = 0;
      // A press begun at edge tp is long at edge tp+LONG; releasing on or
      // before that edge is a short press.
      if (pressing) begin
        if (!pst) begin
          pressing = 0;
          e_b = (mc <= tp + LONG);
        end else if (mc == tp + LONG) begin
          e_a = 1;
        end
      end else if (pst) begin
        pressing = 1;
        tp = mc;
      end
      // Stable level flips after DEB consecutive differing synchronised samples.
      if (p2 != pst) begin
        run++;
        if (run == DEB) begin
          pst = p2;
          run = 0;
        end
      end else begin
        run = 0;
      end
      p2 = p1;
      p1 = push_button;
      // Presence: rise -> d; fall at edge tf -> c at edge tf+OFF-1 unless cancelled.
      if (i2 && !iprev) begin
        e_d = 1;
        armed = 0;
      end else if (!i2 && iprev) begin
        armed = 1;
        tf = mc;
      end else if (armed && mc == tf + OFF - 1) begin
        e_c = 1;
        armed = 0;
      end
      iprev = i2;
      i2 = i1;
      i1 = infrared;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk("model_abcd", int'({a, b, c, d}), int'({e_a, e_b, e_c, e_d}));
  end

  // Pulse monitor for the literal timing checks.
  int a_cnt, b_cnt, c_cnt, d_cnt;
  int a_cyc, b_cyc, c_cyc, d_cyc;
  always @(negedge clk) begin
    if (a) begin a_cnt++; a_cyc = cyc; end
    if (b) begin b_cnt++; b_cyc = cyc; end
    if (c) begin c_cnt++; c_cyc = cyc; end
    if (d) begin d_cnt++; d_cyc = cyc; end
  end

  task automatic clr();
    a_cnt = 0; b_cnt = 0; c_cnt = 0; d_cnt = 0;
    a_cyc = -1; b_cyc = -1; c_cyc = -1; d_cyc = -1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  int t;

  initial begin
    clr();
    // Reset state
    wait_n(3);
    chk("reset_abcd", int'({a, b, c, d}), 0);
    #2 rst = 1'b1;
    wait_n(5);

    // 1 Short press
    clr();
    push_button = 1'b1;
    wait_n(10);
    push_button = 1'b0;
    t = cyc;
    wait_n(30);
    chk("short_b_count", b_cnt, 1);
    chk("short_b_time", b_cyc, t + 7);
    chk("short_a_count", a_cnt, 0);

    // 2 Long press
    clr();
    push_button = 1'b1;
    t = cyc;
    wait_n(40);
    push_button = 1'b0;
    wait_n(30);
    chk("long_a_count", a_cnt, 1);
    chk("long_a_time", a_cyc, t + 27);
    chk("long_b_count", b_cnt, 0);

    // 3 Bounce: 3 high / 2 low for 30 clocks
    clr();
    for (int i = 0; i < 6; i++) begin
      push_button = 1'b1;
      wait_n(3);
      push_button = 1'b0;
      wait_n(2);
    end
    wait_n(40);
    chk("bounce_a_count", a_cnt, 0);
    chk("bounce_b_count", b_cnt, 0);

    // 4 Presence rise and absence timeout
    clr();
    infrared = 1'b1;
    t = cyc;
    wait_n(10);
    chk("pres_d_count", d_cnt, 1);
    chk("pres_d_time", d_cyc, t + 3);
    infrared = 1'b0;
    t = cyc;
    wait_n(60);
    chk("pres_c_count", c_cnt, 1);
    chk("pres_c_time", c_cyc, t + 52);
    wait_n(100);
    chk("pres_c_once", c_cnt, 1);

    // 5 Presence returns mid-timeout
    clr();
    infrared = 1'b1;
    wait_n(10);
    infrared = 1'b0;
    wait_n(30);
    infrared = 1'b1;
    t = cyc;
    wait_n(10);
    chk("ret_d_count", d_cnt, 2);
    chk("ret_d_time", d_cyc, t + 3);
    chk("ret_c_count", c_cnt, 0);
    infrared = 1'b0;
    t = cyc;
    wait_n(60);
    chk("ret_c_restart_count", c_cnt, 1);
    chk("ret_c_restart_time", c_cyc, t + 52);

    // 6 Reset mid-press, infrared high across reset release
    infrared = 1'b1;
    wait_n(10);
    push_button = 1'b1;
    wait_n(15);
    #2 rst = 1'b0;
    #1 chk("midreset_abcd", int'({a, b, c, d}), 0);
    @(negedge clk);
    clr();
    wait_n(2);
    #2 rst = 1'b1;
    t = cyc;
    wait_n(40);
    push_button = 1'b0;
    wait_n(30);
    chk("rstpress_a_count", a_cnt, 1);
    chk("rstpress_a_time", a_cyc, t + 27);
    chk("rstpress_b_count", b_cnt, 0);
    chk("rstir_d_count", d_cnt, 1);
    chk("rstir_d_time", d_cyc, t + 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
